// File: rtl/eth_frame_recorder_if.sv
// Byte-stream, control and BRAM-write signals of the Ethernet frame recorder.
// The master is the byte source / consumer side, the slave is the recorder.
interface eth_frame_recorder_if #(
  parameter int ADDR_W   = 11,
  parameter int LEN_W    = 11,
  parameter int BYTE_LEN = 8
);
  // Stream semantics: in_valid is a one-cycle strobe qualifying in_byte,
  // in_done a one-cycle end-of-frame pulse; there is no backpressure, so
  // the recorder must take every strobe in the cycle it is presented.
  logic                in_valid;
  logic [BYTE_LEN-1:0] in_byte;
  logic                in_done;
  logic                arm;
  logic                frame_ack;
  logic                ram_write_enable;
  logic [ADDR_W-1:0]   ram_write_addr;
  logic [BYTE_LEN-1:0] ram_write_val;
  logic                frame_ready;
  logic [ADDR_W-1:0]   frame_start_addr;
  logic [ADDR_W-1:0]   frame_end_addr;
  logic [LEN_W-1:0]    frame_len;
  logic                truncated;
  logic [7:0]          dropped_cnt;
  logic [2:0]          state_dbg;

  modport master (
    output in_valid, in_byte, in_done, arm, frame_ack,
    input  ram_write_enable, ram_write_addr, ram_write_val, frame_ready,
           frame_start_addr, frame_end_addr, frame_len, truncated,
           dropped_cnt, state_dbg
  );

  modport slave (
    input  in_valid, in_byte, in_done, arm, frame_ack,
    output ram_write_enable, ram_write_addr, ram_write_val, frame_ready,
           frame_start_addr, frame_end_addr, frame_len, truncated,
           dropped_cnt, state_dbg
  );
endinterface

// File: rtl/eth_frame_recorder.sv
// Strips preamble/SFD from received Ethernet bytes, stores the frame into a
// power-of-two ring buffer and reports it until the consumer acknowledges.
module eth_frame_recorder #(
  parameter int RAM_SIZE      = 2048,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int BYTE_LEN      = 8,
  parameter int ADDR_W        = $clog2(RAM_SIZE),
  parameter int LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  eth_frame_recorder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HUNT    = 3'd1,
    S_CAPTURE = 3'd2,
    S_DROP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0]    MAX_LEN  = LEN_W'(MAX_FRAME_LEN);
  localparam logic [BYTE_LEN-1:0] PREAMBLE = BYTE_LEN'(8'h55);
  localparam logic [BYTE_LEN-1:0] SFD      = BYTE_LEN'(8'hD5);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  count;
  logic              trunc;

  // A byte arriving together with in_done is counted before the frame closes,
  // so the close decision works on the post-increment count.
  logic              take_byte;
  logic [LEN_W-1:0]  count_nx;
  logic              trunc_nx;

  assign take_byte = bus.in_valid && (count < MAX_LEN);
  assign count_nx  = count + LEN_W'(take_byte);
  assign trunc_nx  = trunc | (bus.in_valid & ~take_byte);

  assign bus.state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      base                 <= '0;
      count                <= '0;
      trunc                <= 1'b0;
      bus.ram_write_enable <= 1'b0;
      bus.ram_write_addr   <= '0;
      bus.ram_write_val    <= '0;
      bus.frame_ready      <= 1'b0;
      bus.frame_start_addr <= '0;
      bus.frame_end_addr   <= '0;
      bus.frame_len        <= '0;
      bus.truncated        <= 1'b0;
      bus.dropped_cnt      <= '0;
    end else begin
      bus.ram_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.arm) state <= S_HUNT;
        end
        S_HUNT: begin
          if (bus.in_done) begin
            state <= S_HUNT;
          end else if (bus.in_valid) begin
            if (bus.in_byte == SFD) begin
              state <= S_CAPTURE;
              count <= '0;
              trunc <= 1'b0;
            end else if (bus.in_byte != PREAMBLE) begin
              state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (bus.in_done) state <= S_HUNT;
        end
        S_CAPTURE: begin
          if (take_byte) begin
            bus.ram_write_enable <= 1'b1;
            bus.ram_write_addr   <= base + ADDR_W'(count);
            bus.ram_write_val    <= bus.in_byte;
          end
          count <= count_nx;
          trunc <= trunc_nx;
          if (bus.in_done) begin
            if (count_nx == '0) begin
              state <= S_HUNT;
            end else begin
              bus.frame_start_addr <= base;
              bus.frame_end_addr   <= base + ADDR_W'(count_nx);
              bus.frame_len        <= count_nx;
              bus.truncated        <= trunc_nx;
              bus.frame_ready      <= 1'b1;
              state                <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.in_done && bus.dropped_cnt != 8'hFF)
            bus.dropped_cnt <= bus.dropped_cnt + 8'd1;
          if (bus.frame_ack) begin
            base            <= bus.frame_end_addr;
            bus.frame_ready <= 1'b0;
            trunc           <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_recorder.sv
// Randomised bench for eth_frame_recorder: frame-level reference model feeds
// expected writes and reports into queues drained by an output monitor.
module tb_eth_frame_recorder;

  localparam int RAM_SIZE = 2048;
  localparam int MAX_LEN  = 1522;
  localparam int AW       = 11;
  localparam int LW       = 11;
  localparam int RW       = 2 * AW + LW + 1;
  localparam int M_IDLE   = 0;
  localparam int M_ARMED  = 1;
  localparam int M_DONE   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eth_frame_recorder_if #(.ADDR_W(AW), .LEN_W(LW), .BYTE_LEN(8)) bus ();

  eth_frame_recorder #(.RAM_SIZE(RAM_SIZE), .MAX_FRAME_LEN(MAX_LEN), .BYTE_LEN(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [AW+8-1:0] exp_q[$];   // {addr, data}
  logic [RW-1:0]   rep_q[$];   // {start, end, len, truncated}
  logic [RW-1:0]   last_rep = '0;
  int              m_mode = M_IDLE;
  logic [AW-1:0]   m_base = '0;
  int              m_dropped = 0;
  logic [7:0]      fr[$];
  logic            prev_valid = 1'b0;
  logic            prev_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: what a recorder does with one whole byte stream.
  task automatic model_frame(input logic [7:0] q[$]);
    int i, n, stored;
    if (m_mode == M_DONE) begin
      if (m_dropped < 255) m_dropped++;
      return;
    end
    if (m_mode != M_ARMED) return;
    i = 0;
    while (i < q.size() && q[i] == 8'h55) i++;
    if (i >= q.size() || q[i] != 8'hD5) return;
    i++;
    n = q.size() - i;
    if (n == 0) return;
    stored = (n > MAX_LEN) ? MAX_LEN : n;
    for (int k = 0; k < stored; k++) exp_q.push_back({m_base + AW'(k), q[i+k]});
    last_rep = {m_base, m_base + AW'(stored), LW'(stored), (n > MAX_LEN)};
    rep_q.push_back(last_rep);
    m_mode = M_DONE;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [AW+8-1:0] e;
    logic [RW-1:0]   r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (bus.ram_write_enable) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write at %0t",
                     bus.ram_write_addr, bus.ram_write_val, $time);
          end else begin
            e = exp_q.pop_front();
            check("write", {bus.ram_write_addr, bus.ram_write_val}, e);
            check("write_latency", prev_valid, 1);
          end
        end
        if (bus.frame_ready && !prev_ready) begin
          if (rep_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_report: start=0x%0h end=0x%0h len=%0d, expected none",
                     bus.frame_start_addr, bus.frame_end_addr, bus.frame_len);
          end else begin
            r = rep_q.pop_front();
            check("report", {bus.frame_start_addr, bus.frame_end_addr, bus.frame_len, bus.truncated}, r);
          end
        end
        prev_valid = bus.in_valid;
        prev_ready = bus.frame_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit with_done);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_done  = with_done;
    tick();
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    if (m_mode == M_IDLE) m_mode = M_ARMED;
  endtask

  task automatic pulse_ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    if (m_mode == M_DONE) begin
      m_base = last_rep[AW+LW:LW+1];
      m_mode = M_IDLE;
    end
    check("ack_ready_low", bus.frame_ready, 0);
  endtask

  task automatic build_frame(input int pre, input int n, input int first, input bit rnd);
    fr.delete();
    repeat (pre) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int k = 0; k < n; k++)
      fr.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(first + k));
  endtask

  // arm_at >= 0 pulses arm just before byte arm_at (recorder assumed idle).
  task automatic send_stream(input logic [7:0] q[$], input int arm_at, input bit done_on_last);
    logic [7:0] sfx[$];
    if (arm_at >= 0) begin
      if (m_mode == M_IDLE) m_mode = M_ARMED;
      for (int k = arm_at; k < q.size(); k++) sfx.push_back(q[k]);
      model_frame(sfx);
    end else begin
      model_frame(q);
    end
    for (int k = 0; k < q.size(); k++) begin
      if (k == arm_at) begin
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
      end
      drive_byte(q[k], done_on_last && (k == q.size() - 1));
      repeat ($urandom_range(0, 2)) tick();
    end
    if (!done_on_last || q.size() == 0) begin
      bus.in_done = 1'b1;
      tick();
      bus.in_done = 1'b0;
    end
    repeat (3) tick();
    check("frame_ready", bus.frame_ready, (m_mode == M_DONE));
    check("dropped_cnt", bus.dropped_cnt, m_dropped);
  endtask

  task automatic wait_drain();
    int budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("write_queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    bus.ram_write_enable, 0);
    check({tag, "_waddr"}, bus.ram_write_addr, 0);
    check({tag, "_wval"},  bus.ram_write_val, 0);
    check({tag, "_ready"}, bus.frame_ready, 0);
    check({tag, "_start"}, bus.frame_start_addr, 0);
    check({tag, "_end"},   bus.frame_end_addr, 0);
    check({tag, "_len"},   bus.frame_len, 0);
    check({tag, "_trunc"}, bus.truncated, 0);
    check({tag, "_drop"},  bus.dropped_cnt, 0);
    check({tag, "_state"}, bus.state_dbg, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.in_done   = 1'b0;
    bus.arm       = 1'b0;
    bus.frame_ack = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) tick();

    // 64-byte frame at the start of the buffer
    pulse_arm();
    build_frame(7, 64, 1, 1'b0);
    send_stream(fr, -1, 1'b0);
    wait_drain();

    // 10-byte frame follows on
    pulse_ack();
    pulse_arm();
    build_frame(7, 10, 0, 1'b1);
    send_stream(fr, -1, 1'b0);

    // oversize frame is truncated
    pulse_ack();
    pulse_arm();
    build_frame(7, 1600, 0, 1'b1);
    send_stream(fr, -1, 1'b0);
    wait_drain();

    // move base to RAM_SIZE-4, then a frame straddling the wrap with coincident done
    pulse_ack();
    pulse_arm();
    build_frame(7, 448, 0, 1'b1);
    send_stream(fr, -1, 1'b0);
    pulse_ack();
    check("base_before_wrap", m_base, RAM_SIZE - 4);
    pulse_arm();
    build_frame(7, 8, 8'hA0, 1'b0);
    send_stream(fr, -1, 1'b1);

    // frames arriving while a report is held are counted, not stored
    repeat (3) begin
      build_frame(7, 20, 0, 1'b1);
      send_stream(fr, -1, 1'b0);
    end
    check("held_fields", {bus.frame_start_addr, bus.frame_end_addr, bus.frame_len, bus.truncated}, last_rep);

    // arm lands mid-frame: first byte seen is 0x3C, so the frame is dropped
    pulse_ack();
    build_frame(7, 30, 0, 1'b1);
    fr[8] = 8'h3C;
    send_stream(fr, 8, 1'b0);
    build_frame(5, 12, 0, 1'b1);
    send_stream(fr, -1, 1'b0);

    // reset in the middle of a capture
    pulse_ack();
    pulse_arm();
    repeat (7) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({m_base + AW'(k), 8'(8'h70 + k)});
      drive_byte(8'(8'h70 + k), 1'b0);
    end
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    m_mode = M_IDLE;
    m_base = '0;
    m_dropped = 0;
    exp_q.delete();
    rep_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    pulse_arm();
    build_frame(7, 16, 0, 1'b1);
    send_stream(fr, -1, 1'b0);

    // randomised frames, arms and acks
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) != 0) pulse_ack();
      if ($urandom_range(0, 4) != 0) pulse_arm();
      build_frame($urandom_range(0, 7), $urandom_range(0, 80), 0, 1'b1);
      if ($urandom_range(0, 5) == 0) fr[0] = 8'h3C;
      send_stream(fr, -1, 1'($urandom_range(0, 1)));
    end

    wait_drain();
    repeat (3) tick();
    check("reports_drained", rep_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
